// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - CLINT address map, response codes and decode helpers
package clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    DEC_MSIP,
    DEC_CMP_LO,
    DEC_CMP_HI,
    DEC_MTIME_LO,
    DEC_MTIME_HI,
    DEC_NONE
  } dec_e;

  typedef struct packed {
    dec_e       kind;
    logic [2:0] hart;
  } dec_t;

  // Window base is 64 KiB aligned, so only the upper half-word is compared.
  function automatic dec_t decode(input logic [31:0] addr, input logic [15:0] base_hi,
                                  input int nhart);
    dec_t        d;
    logic [15:0] off;
    logic [15:0] rel_msip;
    logic [15:0] rel_cmp;
    d.kind   = DEC_NONE;
    d.hart   = 3'd0;
    off      = addr[15:0];
    rel_msip = off - MSIP_OFF;
    rel_cmp  = off - MTIMECMP_OFF;
    if (addr[31:16] == base_hi && addr[1:0] == 2'b00) begin
      if (rel_msip < 16'(4 * nhart)) begin
        d.kind = DEC_MSIP;
        d.hart = rel_msip[4:2];
      end else if (rel_cmp < 16'(8 * nhart)) begin
        d.kind = rel_cmp[2] ? DEC_CMP_HI : DEC_CMP_LO;
        d.hart = rel_cmp[5:3];
      end else if (off == MTIME_OFF) begin
        d.kind = DEC_MTIME_LO;
      end else if (off == MTIME_OFF + 16'd4) begin
        d.kind = DEC_MTIME_HI;
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// rtl/clint_tick_gen.sv - prescaler emitting a one-cycle tick every PRESCALE clocks
module clint_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 16'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_mt.sv
// rtl/clint_mt.sv - multi-hart CLINT: mtime, mtimecmp, msip behind an AXI4-Lite slave
module clint_mt
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NHART     = 1,
  parameter int          PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      CLINT_araddr,
  input  logic             CLINT_arvalid,
  output logic             CLINT_arready,
  output logic [31:0]      CLINT_rdata,
  output logic [1:0]       CLINT_rresp,
  output logic             CLINT_rvalid,
  input  logic             CLINT_rready,
  input  logic [31:0]      CLINT_awaddr,
  input  logic             CLINT_awvalid,
  output logic             CLINT_awready,
  input  logic [31:0]      CLINT_wdata,
  input  logic [3:0]       CLINT_wstrb,
  input  logic             CLINT_wvalid,
  output logic             CLINT_wready,
  output logic [1:0]       CLINT_bresp,
  output logic             CLINT_bvalid,
  input  logic             CLINT_bready,
  output logic [NHART-1:0] mtip,
  output logic [NHART-1:0] msip
);

  logic                   ready_en_q, ready_en_d;
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic                   aw_valid_q, aw_valid_d;
  logic [31:0]            aw_addr_q, aw_addr_d;
  logic                   w_valid_q, w_valid_d;
  logic [31:0]            w_data_q, w_data_d;
  logic [3:0]             w_strb_q, w_strb_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [63:0]            mtime_q, mtime_d;
  logic [NHART-1:0][63:0] mtimecmp_q, mtimecmp_d;
  logic [NHART-1:0]       msip_q, msip_d;
  logic [NHART-1:0]       mtip_q, mtip_d;

  logic        tick;
  logic        ar_hs, aw_hs, w_hs, commit;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  dec_t        rd_dec, wr_dec;

  clint_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // ready_en keeps every ready low while reset is held and for the first edge after it.
  assign CLINT_arready = ready_en_q && !rvalid_q;
  assign CLINT_awready = ready_en_q && !aw_valid_q && !bvalid_q;
  assign CLINT_wready  = ready_en_q && !w_valid_q && !bvalid_q;
  assign CLINT_rvalid  = rvalid_q;
  assign CLINT_rdata   = rdata_q;
  assign CLINT_rresp   = rresp_q;
  assign CLINT_bvalid  = bvalid_q;
  assign CLINT_bresp   = bresp_q;
  assign mtip          = mtip_q;
  assign msip          = msip_q;

  assign ar_hs   = CLINT_arvalid && CLINT_arready;
  assign aw_hs   = CLINT_awvalid && CLINT_awready;
  assign w_hs    = CLINT_wvalid && CLINT_wready;
  assign wr_addr = aw_valid_q ? aw_addr_q : CLINT_awaddr;
  assign wr_data = w_valid_q ? w_data_q : CLINT_wdata;
  assign wr_strb = w_valid_q ? w_strb_q : CLINT_wstrb;
  assign commit  = (aw_valid_q || aw_hs) && (w_valid_q || w_hs);
  assign rd_dec  = decode(CLINT_araddr, BASE_ADDR[31:16], NHART);
  assign wr_dec  = decode(wr_addr, BASE_ADDR[31:16], NHART);

  always_comb begin
    ready_en_d = 1'b1;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    aw_valid_d = aw_valid_q;
    aw_addr_d  = aw_addr_q;
    w_valid_d  = w_valid_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;

    for (int h = 0; h < NHART; h++) begin
      mtip_d[h] = (mtime_q >= mtimecmp_q[h]);
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = 32'd0;
      rresp_d  = RESP_OKAY;
      case (rd_dec.kind)
        DEC_MSIP: begin
          for (int h = 0; h < NHART; h++) begin
            if (rd_dec.hart == 3'(h)) rdata_d = {31'd0, msip_q[h]};
          end
        end
        DEC_CMP_LO: begin
          for (int h = 0; h < NHART; h++) begin
            if (rd_dec.hart == 3'(h)) rdata_d = mtimecmp_q[h][31:0];
          end
        end
        DEC_CMP_HI: begin
          for (int h = 0; h < NHART; h++) begin
            if (rd_dec.hart == 3'(h)) rdata_d = mtimecmp_q[h][63:32];
          end
        end
        DEC_MTIME_LO: rdata_d = mtime_q[31:0];
        DEC_MTIME_HI: rdata_d = mtime_q[63:32];
        default:      rresp_d = RESP_SLVERR;
      endcase
    end else if (rvalid_q && CLINT_rready) begin
      rvalid_d = 1'b0;
    end

    if (aw_hs) begin
      aw_valid_d = 1'b1;
      aw_addr_d  = CLINT_awaddr;
    end
    if (w_hs) begin
      w_valid_d = 1'b1;
      w_data_d  = CLINT_wdata;
      w_strb_d  = CLINT_wstrb;
    end

    // A bus write to one mtime half replaces that half and suppresses the tick.
    if (commit) begin
      aw_valid_d = 1'b0;
      w_valid_d  = 1'b0;
      bvalid_d   = 1'b1;
      bresp_d    = (wr_dec.kind == DEC_NONE) ? RESP_SLVERR : RESP_OKAY;
      case (wr_dec.kind)
        DEC_MSIP: begin
          for (int h = 0; h < NHART; h++) begin
            if (wr_dec.hart == 3'(h) && wr_strb[0]) msip_d[h] = wr_data[0];
          end
        end
        DEC_CMP_LO: begin
          for (int h = 0; h < NHART; h++) begin
            if (wr_dec.hart == 3'(h))
              mtimecmp_d[h][31:0] = strb_merge(mtimecmp_q[h][31:0], wr_data, wr_strb);
          end
        end
        DEC_CMP_HI: begin
          for (int h = 0; h < NHART; h++) begin
            if (wr_dec.hart == 3'(h))
              mtimecmp_d[h][63:32] = strb_merge(mtimecmp_q[h][63:32], wr_data, wr_strb);
          end
        end
        DEC_MTIME_LO: mtime_d = {mtime_q[63:32], strb_merge(mtime_q[31:0], wr_data, wr_strb)};
        DEC_MTIME_HI: mtime_d = {strb_merge(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
        default: ;
      endcase
    end else if (bvalid_q && CLINT_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
      rresp_q    <= RESP_OKAY;
      aw_valid_q <= 1'b0;
      aw_addr_q  <= 32'd0;
      w_valid_q  <= 1'b0;
      w_data_q   <= 32'd0;
      w_strb_q   <= 4'd0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      msip_q     <= '0;
      mtip_q     <= '0;
    end else begin
      ready_en_q <= ready_en_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      aw_valid_q <= aw_valid_d;
      aw_addr_q  <= aw_addr_d;
      w_valid_q  <= w_valid_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
    end
  end

endmodule
